// File: rtl/hall_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hall_pkg
// Description : Shared hall-sensor definitions: step type, 6-step code table,
//               invalid-code constants and small lookup helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package hall_pkg;

    typedef logic [2:0] step_t;
    typedef logic [2:0] hall_code_t;

    // {SA,SB,SC} per step; element [0] is step 0.
    localparam logic [5:0][2:0] c_hall_code = {
        3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101
    };

    localparam hall_code_t c_code_invalid_lo = 3'b000;
    localparam hall_code_t c_code_invalid_hi = 3'b111;
    localparam step_t      c_step_last       = 3'd5;

    function automatic hall_code_t hall_code(input step_t idx);
        hall_code_t code;
        case (idx)
            3'd0:    code = c_hall_code[0];
            3'd1:    code = c_hall_code[1];
            3'd2:    code = c_hall_code[2];
            3'd3:    code = c_hall_code[3];
            3'd4:    code = c_hall_code[4];
            3'd5:    code = c_hall_code[5];
            default: code = c_hall_code[0];
        endcase
        return code;
    endfunction

    function automatic step_t step_advance(input step_t idx, input logic rev);
        step_t nxt;
        if (rev) nxt = (idx == 3'd0) ? c_step_last : idx - 3'd1;
        else     nxt = (idx >= c_step_last) ? 3'd0 : idx + 3'd1;
        return nxt;
    endfunction

    function automatic logic is_valid_code(input hall_code_t code);
        return (code != c_code_invalid_lo) && (code != c_code_invalid_hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hall_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : hall_step_timer
// Description : Per-step period counter with pending-period shadow register
//               and step-boundary strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module hall_step_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_run,
    input  logic                i_count_en,
    input  logic                i_cfg_valid,
    input  logic [PERIOD_W-1:0] i_cfg_period,
    output logic                o_boundary,
    output logic                o_stop,
    output logic [PERIOD_W-1:0] o_active_period
);

    localparam logic [PERIOD_W-1:0] c_one = PERIOD_W'(1);

    logic [PERIOD_W-1:0] r_active;
    logic [PERIOD_W-1:0] r_pending;
    logic [PERIOD_W-1:0] r_count;
    logic                r_pend_flag;
    logic                w_boundary;

    assign w_boundary = i_run && i_count_en && (r_active != '0) &&
                        (r_count == r_active - c_one);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active    <= '0;
            r_pending   <= '0;
            r_count     <= '0;
            r_pend_flag <= 1'b0;
        end else if (!i_run) begin
            r_count <= '0;
            if (i_cfg_valid) r_active <= i_cfg_period;
        end else begin
            if (!i_count_en) begin
                r_count <= '0;
            end else if (w_boundary) begin
                r_count <= '0;
                if (r_pend_flag) r_active <= r_pending;
            end else begin
                r_count <= r_count + c_one;
            end
            // A write on the boundary cycle still lands in the shadow, after
            // the previous shadow value has been promoted.
            if (i_cfg_valid) begin
                r_pending   <= i_cfg_period;
                r_pend_flag <= 1'b1;
            end else if (w_boundary) begin
                r_pend_flag <= 1'b0;
            end
        end
    end

    assign o_boundary      = w_boundary;
    assign o_stop          = w_boundary && r_pend_flag && (r_pending == '0);
    assign o_active_period = r_active;

endmodule
`default_nettype wire

// File: rtl/hall_emulator.sv
`default_nettype none
// ============================================================================
// Module      : hall_emulator
// Description : BLDC hall-pattern generator with programmable step period,
//               direction and bounded SA glitch injection.
// Revision    : 1.0 - initial release
// ============================================================================
module hall_emulator
    import hall_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int GLITCH_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                dir,
    input  logic                cfg_valid,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                glitch_req,
    input  logic [GLITCH_W-1:0] glitch_len,
    output logic                SA_out,
    output logic                SB_out,
    output logic                SC_out,
    output step_t               step_idx,
    output logic                step_pulse,
    output logic                glitch_busy
);

    localparam logic [0:0]          c_st_idle    = 1'b0;
    localparam logic [0:0]          c_st_run     = 1'b1;
    localparam logic [GLITCH_W-1:0] c_glitch_one = GLITCH_W'(1);

    logic [0:0]          r_state;
    step_t               r_step_idx;
    logic                r_sa;
    logic                r_sb;
    logic                r_sc;
    logic                r_step_pulse;
    logic                r_glitch_busy;
    logic [GLITCH_W-1:0] r_glitch_cnt;

    logic                w_run;
    logic                w_boundary;
    logic                w_stop;
    logic [PERIOD_W-1:0] w_active_period;
    logic                w_glitch_accept;
    logic                w_busy_next;
    step_t               w_idx_next;
    hall_code_t          w_code_next;

    assign w_run = (r_state == c_st_run);

    hall_step_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk             (clk),
        .rst             (rst),
        .i_run           (w_run),
        .i_count_en      (enable),
        .i_cfg_valid     (cfg_valid),
        .i_cfg_period    (cfg_period),
        .o_boundary      (w_boundary),
        .o_stop          (w_stop),
        .o_active_period (w_active_period)
    );

    assign w_idx_next      = w_boundary ? step_advance(r_step_idx, dir) : r_step_idx;
    assign w_code_next     = hall_code(w_idx_next);
    assign w_glitch_accept = w_run && enable && !w_stop && glitch_req &&
                             !r_glitch_busy && (glitch_len != '0);

    // A new step always comes out clean unless a glitch starts on it.
    always_comb begin
        w_busy_next = r_glitch_busy;
        if (w_glitch_accept)
            w_busy_next = 1'b1;
        else if (!w_run || !enable || w_boundary)
            w_busy_next = 1'b0;
        else if (r_glitch_busy && (r_glitch_cnt == c_glitch_one))
            w_busy_next = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_step_idx    <= 3'd0;
            r_sa          <= 1'b1;
            r_sb          <= 1'b0;
            r_sc          <= 1'b1;
            r_step_pulse  <= 1'b0;
            r_glitch_busy <= 1'b0;
            r_glitch_cnt  <= '0;
        end else begin
            case (r_state)
                c_st_idle: if (enable && (w_active_period != '0)) r_state <= c_st_run;
                c_st_run:  if (!enable || w_stop) r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase

            r_step_idx    <= w_idx_next;
            r_step_pulse  <= w_boundary;
            r_glitch_busy <= w_busy_next;
            if (w_glitch_accept)
                r_glitch_cnt <= glitch_len;
            else if (r_glitch_busy)
                r_glitch_cnt <= r_glitch_cnt - c_glitch_one;

            r_sa <= w_code_next[2] ^ w_busy_next;
            r_sb <= w_code_next[1];
            r_sc <= w_code_next[0];
        end
    end

    assign SA_out      = r_sa;
    assign SB_out      = r_sb;
    assign SC_out      = r_sc;
    assign step_idx    = r_step_idx;
    assign step_pulse  = r_step_pulse;
    assign glitch_busy = r_glitch_busy;

endmodule
`default_nettype wire
